// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, control-field encodings, FSM states and the packed control word
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001,
        ALU_LUI  = 4'b1111
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } mem_to_reg_e;

    typedef enum logic {RUN, LOAD_WAIT} state_e;

    typedef struct packed {
        alu_op_e     alu;
        imm_sel_e    imm;
        mem_to_reg_e wb;
        logic        reg_write;
        logic        op_a;
        logic        op_b;
        logic        load;
        logic        store;
        logic        mem_en;
        logic        branch;
        logic        next_sel;
        logic        jalr;
        logic        illegal;
    } ctrl_word_t;

    // f7 only distinguishes SUB from ADD and SRA from SRL
    function automatic alu_op_e alu_f(input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return f7 ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: combinational opcode/fun3/fun7 to control-word decoder
module ctrl_decode_comb
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] fun3_i,
    input  logic       fun7_i,
    output ctrl_word_t word_o
);

    // decode by opcode, then squash side-effect strobes on illegal encodings
    always_comb begin
        word_o = '0;
        case (opcode_i)
            OP_R: begin
                word_o.alu       = alu_f(fun3_i, fun7_i);
                word_o.reg_write = 1'b1;
                word_o.illegal   = fun7_i & (fun3_i != 3'b000) & (fun3_i != 3'b101);
            end
            OP_I: begin
                word_o.alu       = alu_f(fun3_i, (fun3_i == 3'b101) & fun7_i);
                word_o.reg_write = 1'b1;
                word_o.op_b      = 1'b1;
                word_o.illegal   = (fun3_i == 3'b001) & fun7_i;
            end
            OP_STORE: begin
                word_o.imm    = IMM_S;
                word_o.op_b   = 1'b1;
                word_o.store  = 1'b1;
                word_o.mem_en = 1'b1;
            end
            OP_LOAD: begin
                word_o.wb   = WB_MEM;
                word_o.op_b = 1'b1;
                word_o.load = 1'b1;
            end
            OP_BRANCH: begin
                word_o.imm    = IMM_B;
                word_o.op_a   = 1'b1;
                word_o.op_b   = 1'b1;
                word_o.branch = 1'b1;
            end
            OP_JAL: begin
                word_o.imm       = IMM_J;
                word_o.wb        = WB_PC4;
                word_o.reg_write = 1'b1;
                word_o.op_a      = 1'b1;
                word_o.op_b      = 1'b1;
                word_o.next_sel  = 1'b1;
            end
            OP_JALR: begin
                word_o.wb        = WB_PC4;
                word_o.reg_write = 1'b1;
                word_o.op_b      = 1'b1;
                word_o.jalr      = 1'b1;
            end
            OP_LUI: begin
                word_o.alu       = ALU_LUI;
                word_o.imm       = IMM_U;
                word_o.reg_write = 1'b1;
                word_o.op_b      = 1'b1;
            end
            OP_AUIPC: begin
                word_o.imm       = IMM_U;
                word_o.reg_write = 1'b1;
                word_o.op_a      = 1'b1;
                word_o.op_b      = 1'b1;
            end
            default: word_o.illegal = 1'b1;
        endcase
        if (word_o.illegal) begin
            word_o.reg_write = 1'b0;
            word_o.store     = 1'b0;
            word_o.mem_en    = 1'b0;
            word_o.load      = 1'b0;
            word_o.branch    = 1'b0;
            word_o.next_sel  = 1'b0;
            word_o.jalr      = 1'b0;
        end
    end

endmodule

// File: rtl/control_unit_pipe.sv
// control_unit_pipe: registered, handshaked decode-stage control unit with load-wait stall
module control_unit_pipe
    import ctrl_pkg::*;
#(
    parameter int FUNCTION3    = 3,
    parameter int OPCODE       = 7,
    parameter int ALU_CONTROL  = 4,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic [OPCODE-1:0]      opcode_i,
    input  logic [FUNCTION3-1:0]   fun3,
    input  logic                   fun7,
    input  logic                   flush_i,
    input  logic                   dm_valid,
    input  logic                   ex_ready_i,
    output logic                   ctrl_valid_o,
    output logic [ALU_CONTROL-1:0] alu_control,
    output logic [2:0]             imm_sel,
    output logic [1:0]             mem_to_reg,
    output logic                   reg_write_o,
    output logic                   operand_a_o,
    output logic                   operand_b_o,
    output logic                   Load,
    output logic                   Store,
    output logic                   mem_en,
    output logic                   Branch,
    output logic                   next_sel,
    output logic                   Jalr,
    output logic                   illegal_o,
    output logic                   load_wb_o,
    output logic                   load_err_o,
    output logic                   stall_o
);

    localparam int CW = $clog2(LOAD_TIMEOUT);

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic           valid_q;
    logic           wb_q;
    logic           err_q;
    ctrl_word_t     word_q;
    ctrl_word_t     word_d;
    logic           accept;

    ctrl_decode_comb u_dec (
        .opcode_i (opcode_i),
        .fun3_i   (fun3),
        .fun7_i   (fun7),
        .word_o   (word_d)
    );

    assign instr_ready_o = (state_q == RUN) & (!valid_q | ex_ready_i);
    assign accept        = instr_valid_i & instr_ready_o;
    assign stall_o       = (state_q == LOAD_WAIT);

    // handshake, output register and load-wait FSM with timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            word_q  <= '0;
            wb_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wb_q  <= 1'b0;
            err_q <= 1'b0;
            if (state_q == RUN) begin
                if (flush_i) begin
                    valid_q <= 1'b0;
                end else if (accept) begin
                    word_q  <= word_d;
                    valid_q <= 1'b1;
                    if (word_d.load) begin
                        state_q <= LOAD_WAIT;
                        cnt_q   <= '0;
                    end
                end else if (ex_ready_i) begin
                    valid_q <= 1'b0;
                end
            end else begin
                if (ex_ready_i) valid_q <= 1'b0;
                if (dm_valid) begin
                    wb_q    <= 1'b1;
                    state_q <= RUN;
                end else if (cnt_q == CW'(LOAD_TIMEOUT - 1)) begin
                    err_q   <= 1'b1;
                    state_q <= RUN;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign ctrl_valid_o = valid_q;
    assign alu_control  = word_q.alu;
    assign imm_sel      = word_q.imm;
    assign mem_to_reg   = word_q.wb;
    assign reg_write_o  = word_q.reg_write;
    assign operand_a_o  = word_q.op_a;
    assign operand_b_o  = word_q.op_b;
    assign Load         = word_q.load;
    assign Store        = word_q.store;
    assign mem_en       = word_q.mem_en;
    assign Branch       = word_q.branch;
    assign next_sel     = word_q.next_sel;
    assign Jalr         = word_q.jalr;
    assign illegal_o    = word_q.illegal;
    assign load_wb_o    = wb_q;
    assign load_err_o   = err_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// tb_control_unit_pipe: directed self-checking bench for control_unit_pipe
module tb_control_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid_i, instr_ready_o;
    logic [6:0] opcode_i;
    logic [2:0] fun3;
    logic       fun7, flush_i, dm_valid, ex_ready_i, ctrl_valid_o;
    logic [3:0] alu_control;
    logic [2:0] imm_sel;
    logic [1:0] mem_to_reg;
    logic       reg_write_o, operand_a_o, operand_b_o, Load, Store, mem_en;
    logic       Branch, next_sel, Jalr, illegal_o, load_wb_o, load_err_o, stall_o;

    int n_chk  = 0;
    int n_fail = 0;

    control_unit_pipe #(.LOAD_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .opcode_i(opcode_i), .fun3(fun3), .fun7(fun7),
        .flush_i(flush_i), .dm_valid(dm_valid), .ex_ready_i(ex_ready_i),
        .ctrl_valid_o(ctrl_valid_o), .alu_control(alu_control),
        .imm_sel(imm_sel), .mem_to_reg(mem_to_reg),
        .reg_write_o(reg_write_o), .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
        .Load(Load), .Store(Store), .mem_en(mem_en), .Branch(Branch),
        .next_sel(next_sel), .Jalr(Jalr), .illegal_o(illegal_o),
        .load_wb_o(load_wb_o), .load_err_o(load_err_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic f7);
        instr_valid_i = v;
        opcode_i      = op;
        fun3          = f3;
        fun7          = f7;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 7'd0, 3'd0, 1'b0);
        flush_i = 1'b0; dm_valid = 1'b0; ex_ready_i = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", ctrl_valid_o, 0);
        chk("rst_alu", alu_control, 0);
        chk("rst_regwr", reg_write_o, 0);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_wb", load_wb_o, 0);
        chk("rst_err", load_err_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_ready", instr_ready_o, 1);

        // back-to-back ALU stream
        drive(1'b1, 7'b0110011, 3'b000, 1'b0); tick();
        chk("add_valid", ctrl_valid_o, 1);
        chk("add_alu", alu_control, 4'b0000);
        chk("add_regwr", reg_write_o, 1);
        chk("add_opb", operand_b_o, 0);
        drive(1'b1, 7'b0110011, 3'b000, 1'b1); tick();
        chk("sub_alu", alu_control, 4'b0001);
        drive(1'b1, 7'b0010011, 3'b101, 1'b1); tick();
        chk("srai_alu", alu_control, 4'b0111);
        chk("srai_opb", operand_b_o, 1);
        drive(1'b1, 7'b0010011, 3'b000, 1'b1); tick();
        chk("addi_alu", alu_control, 4'b0000);
        chk("addi_illegal", illegal_o, 0);
        chk("addi_regwr", reg_write_o, 1);
        drive(1'b0, 7'b0010011, 3'b000, 1'b0); tick();
        chk("handoff_valid", ctrl_valid_o, 0);

        // load with data three cycles later, add queued behind it
        drive(1'b1, 7'b0000011, 3'b010, 1'b0); tick();
        chk("lw_valid", ctrl_valid_o, 1);
        chk("lw_load", Load, 1);
        chk("lw_m2r", mem_to_reg, 2'b01);
        chk("lw_regwr", reg_write_o, 0);
        chk("lw_stall0", stall_o, 1);
        drive(1'b1, 7'b0110011, 3'b000, 1'b0); #1;
        chk("lw_ready0", instr_ready_o, 0);
        tick();
        chk("lw_stall1", stall_o, 1);
        chk("lw_valid1", ctrl_valid_o, 0);
        tick();
        chk("lw_stall2", stall_o, 1);
        chk("lw_ready2", instr_ready_o, 0);
        chk("lw_wb_early", load_wb_o, 0);
        dm_valid = 1'b1; tick();
        dm_valid = 1'b0; #1;
        chk("lw_stall3", stall_o, 0);
        chk("lw_wb", load_wb_o, 1);
        chk("lw_ready3", instr_ready_o, 1);
        chk("lw_noacc", ctrl_valid_o, 0);
        tick();
        chk("lw_wb_end", load_wb_o, 0);
        chk("add2_valid", ctrl_valid_o, 1);
        chk("add2_regwr", reg_write_o, 1);
        chk("add2_load", Load, 0);

        // load timeout
        drive(1'b1, 7'b0000011, 3'b010, 1'b0); tick();
        drive(1'b0, 7'b0000000, 3'b000, 1'b0);
        chk("to_stall0", stall_o, 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("to_stall%0d", i), stall_o, 1);
            chk($sformatf("to_err%0d", i), load_err_o, 0);
        end
        tick();
        chk("to_err", load_err_o, 1);
        chk("to_stall16", stall_o, 0);
        chk("to_wb", load_wb_o, 0);
        dm_valid = 1'b1; tick();
        dm_valid = 1'b0;
        chk("to_err_end", load_err_o, 0);
        chk("run_dm_ignored", load_wb_o, 0);

        // jal held under backpressure, then flush with same-cycle accept
        drive(1'b1, 7'b1101111, 3'b000, 1'b0); tick();
        chk("jal_imm", imm_sel, 3'b011);
        chk("jal_m2r", mem_to_reg, 2'b10);
        chk("jal_next", next_sel, 1);
        ex_ready_i = 1'b0;
        drive(1'b1, 7'b0110011, 3'b000, 1'b0); #1;
        chk("bp_ready", instr_ready_o, 0);
        tick();
        chk("hold1_imm", imm_sel, 3'b011);
        chk("hold1_valid", ctrl_valid_o, 1);
        tick();
        chk("hold2_next", next_sel, 1);
        chk("hold2_m2r", mem_to_reg, 2'b10);
        ex_ready_i = 1'b1; flush_i = 1'b1;
        drive(1'b1, 7'b0000011, 3'b010, 1'b0); #1;
        chk("fl_ready", instr_ready_o, 1);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 7'b0000000, 3'b000, 1'b0);
        chk("fl_valid", ctrl_valid_o, 0);
        chk("fl_stall", stall_o, 0);
        tick();
        chk("fl_stall2", stall_o, 0);

        // illegal encodings and a few other formats
        drive(1'b1, 7'b1111111, 3'b000, 1'b0); tick();
        chk("ill_op", illegal_o, 1);
        chk("ill_op_regwr", reg_write_o, 0);
        chk("ill_op_memen", mem_en, 0);
        drive(1'b1, 7'b0110011, 3'b010, 1'b1); tick();
        chk("ill_r", illegal_o, 1);
        chk("ill_r_regwr", reg_write_o, 0);
        drive(1'b1, 7'b0100011, 3'b010, 1'b0); tick();
        chk("sw_illegal", illegal_o, 0);
        chk("sw_memen", mem_en, 1);
        chk("sw_imm", imm_sel, 3'b001);
        drive(1'b1, 7'b0110111, 3'b000, 1'b0); tick();
        chk("lui_alu", alu_control, 4'b1111);
        chk("lui_imm", imm_sel, 3'b100);
        drive(1'b1, 7'b1100011, 3'b000, 1'b0); tick();
        chk("beq_branch", Branch, 1);
        chk("beq_opa", operand_a_o, 1);
        chk("beq_regwr", reg_write_o, 0);

        // asynchronous reset while waiting on a load
        drive(1'b1, 7'b0000011, 3'b010, 1'b0); tick();
        drive(1'b0, 7'b0000000, 3'b000, 1'b0);
        chk("rlw_stall", stall_o, 1);
        rst = 1'b1; #1;
        chk("rlw_stall_rst", stall_o, 0);
        chk("rlw_valid_rst", ctrl_valid_o, 0);
        chk("rlw_load_rst", Load, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("rlw_ready", instr_ready_o, 1);
        chk("rlw_wb", load_wb_o, 0);
        chk("rlw_err", load_err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit_pipe.md
# control_unit_pipe

Registered, handshaked successor to the decode-stage control decoder of the rv32i pipeline. Decodes opcode/fun3/fun7 into the full control word and holds it in an output register with valid/ready flow control toward execute. A load-wait state machine stalls decode while a load is outstanding, with a bounded timeout. Flush from branch/jump resolution discards the pending instruction. Sits between the IF/ID register and the ID/EX stage.

## Interface
- FUNCTION3, 3: fun3 width
- OPCODE, 7: opcode width
- ALU_CONTROL, 4: alu_control width
- LOAD_TIMEOUT, 16: max cycles waited in LOAD_WAIT, ≥2; counter width $clog2(LOAD_TIMEOUT)
- clk  input  1  clock, rising edge
- rst  input  1  reset; one clock; asynchronous, active-high
- instr_valid_i  input  1  decode fields valid
- instr_ready_o  output  1  block accepts fields this cycle
- opcode_i  input  OPCODE  instruction opcode
- fun3  input  FUNCTION3  instruction fun3
- fun7  input  1  instruction bit 30
- flush_i  input  1  redirect from execute, drop pending work
- dm_valid  input  1  load data returned by data memory
- ex_ready_i  input  1  execute accepts control word
- ctrl_valid_o  output  1  control word valid
- alu_control  output  ALU_CONTROL  ALU op
- imm_sel  output  3  immediate format
- mem_to_reg  output  2  writeback source
- reg_write_o, operand_a_o, operand_b_o, Load, Store, mem_en, Branch, next_sel, Jalr  output  1 each  control strobes
- illegal_o  output  1  unsupported opcode/fun combination
- load_wb_o  output  1  one-cycle register-file write strobe for load data
- load_err_o  output  1  one-cycle pulse on load timeout
- stall_o  output  1  high in LOAD_WAIT

## Operation
- Decode: r_type 0110011, i_type 0010011, store 0100011, load 0000011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
- alu_control: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, LUI-pass-B 1111; load/store/branch/jal/jalr/auipc use ADD.
- i_type: fun7 checked only for fun3=001/101; other fun3 ignore fun7 (it is immediate). r_type: fun7=1 legal only with fun3 000/101.
- imm_sel: I (i_type, load, jalr) 000, S 001, B 010, J 011, U (lui, auipc) 100, others 000.
- mem_to_reg: load 01, jal/jalr 10, else 00.
- reg_write_o: r_type, i_type, jal, jalr, lui, auipc; loads write only via load_wb_o.
- operand_a_o: branch, jal, auipc. operand_b_o: all except r_type. mem_en = Store. next_sel = jal.
- Illegal: illegal_o=1, reg_write_o, Store, mem_en, Load, Branch, next_sel, Jalr all 0. All outputs fully assigned; no latches.
- FSM RUN: instr_ready_o = !ctrl_valid_o | ex_ready_i. Accept = instr_valid_i & instr_ready_o: register word, ctrl_valid_o=1. Accepted load -> LOAD_WAIT, counter cleared.
- FSM LOAD_WAIT: instr_ready_o=0, stall_o=1, counter increments each cycle. dm_valid -> load_wb_o pulse, RUN. Counter reaching LOAD_TIMEOUT-1 without dm_valid -> load_err_o pulse, RUN. dm_valid wins on same cycle as timeout.
- Output word held stable while ctrl_valid_o & !ex_ready_i; ctrl_valid_o clears on hand-off with no new accept.
- flush_i: clears ctrl_valid_o next cycle; same-cycle accept is consumed and discarded (no LOAD_WAIT entry). Flush ignored in LOAD_WAIT. dm_valid in RUN ignored.

## Timing
- Reset: state RUN, counter 0, every registered output 0 (ctrl_valid_o, control word, illegal_o, load_wb_o, load_err_o); stall_o 0; instr_ready_o 1 after reset.
- Accept-to-ctrl_valid_o latency 1 cycle; full throughput 1 instruction/cycle when ex_ready_i high.
- load_wb_o and load_err_o registered, one cycle after the triggering edge, width exactly one cycle.
- Reset mid-LOAD_WAIT: returns to RUN immediately, no pulse.

## Structure
- Package ctrl_pkg: opcode localparams, alu_op_e, imm_sel_e, mem_to_reg_e, state_e {RUN, LOAD_WAIT}, packed ctrl_word_t.
- Sub-module ctrl_decode_comb: pure combinational decoder fields -> ctrl_word_t; top holds FSM, counter, output register.

## Test plan
- Reset asserted mid-stream -> all outputs 0, instr_ready_o=1 after release.
- Stream add (0110011/000/0), sub (000/1), srai (0010011/101/1), addi with fun7=1 -> alu 0000,0001,0111,0000 on consecutive cycles, reg_write_o=1.
- lw then add, dm_valid 3 cycles later -> stall_o high 3 cycles, instr_ready_o 0, load_wb_o one pulse, add accepted next cycle.
- lw with no dm_valid, LOAD_TIMEOUT=16 -> load_err_o pulse after 16 cycles, back to RUN.
- jal with ex_ready_i low 2 cycles -> word held (imm_sel 011, mem_to_reg 10, next_sel 1); flush_i with accept -> ctrl_valid_o 0 next cycle.
- opcode 1111111 and r_type fun3=010 fun7=1 -> illegal_o=1, reg_write_o=0, mem_en=0.
